// File: rtl/pulse_pkg.sv
// Shared duty encodings and the duty-pattern decoder
// for the pulse channel.
package pulse_pkg;

  typedef enum logic [1:0] {
    DUTY_12 = 2'd0,
    DUTY_25 = 2'd1,
    DUTY_50 = 2'd2,
    DUTY_75 = 2'd3
  } duty_e;

  // lo: step in first Q, hi1: last Q, hi3: last 3Q
  function automatic logic duty_pattern(
    input duty_e d,
    input logic  lo,
    input logic  hi1,
    input logic  hi3
  );
    logic p;
    case (d)
      DUTY_12: p = hi1;
      DUTY_25: p = hi1 | lo;
      DUTY_50: p = hi3 | lo;
      DUTY_75: p = ~(hi1 | lo);
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pulse_len_ctr.sv
// Length counter: load > trigger reload > tick,
// with a same-update expiry flag.
module pulse_len_ctr
  import pulse_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] val_i,
  input  logic             en_i,
  input  logic             tick_i,
  output logic             expire_o
);

  localparam logic [LEN_W:0] LEN_MAX =
    {1'b1, {LEN_W{1'b0}}};

  logic [LEN_W:0] cnt_q;
  logic [LEN_W:0] cnt_d;
  logic           expire_d;
  logic           cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d = LEN_MAX - {1'b0, val_i};
    end else if (trigger_i) begin
      // a trigger swallows any tick in the same cycle
      if (cnt_zero) cnt_d = LEN_MAX;
    end else if (tick_i && en_i && !cnt_zero) begin
      cnt_d    = cnt_q - (LEN_W+1)'(1);
      expire_d = (cnt_q == (LEN_W+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = expire_d;

endmodule

// File: rtl/pulse_channel.sv
// Pulse waveform channel: frequency timer, step sequencer,
// duty pattern and length-limited run time.
module pulse_channel
  import pulse_pkg::*;
#(
  parameter int FREQ_W = 11,
  parameter int STEPS  = 8,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [FREQ_W-1:0] freq,
  input  logic [1:0]        duty,
  input  logic              len_load,
  input  logic [LEN_W-1:0]  len_val,
  input  logic              len_en,
  input  logic              len_tick,
  output logic              out,
  output logic              active
);

  localparam int SW = $clog2(STEPS);
  localparam int Q  = STEPS / 8;
  localparam logic [FREQ_W:0] PERIOD_MAX =
    {1'b1, {FREQ_W{1'b0}}};

  logic [FREQ_W:0] timer_q;
  logic [FREQ_W:0] timer_d;
  logic [FREQ_W:0] reload;
  logic [SW-1:0]   step_q;
  logic [SW-1:0]   step_d;
  logic            active_q;
  logic            active_d;
  logic            out_q;
  logic            out_d;
  logic            expire;
  logic            lo_band;
  logic            hi1;
  logic            hi3;

  // one extra bit so freq=0 yields a full 2^FREQ_W period
  assign reload = PERIOD_MAX - {1'b0, freq};

  assign lo_band = (step_q < SW'(Q));
  assign hi1     = (step_q >= SW'(STEPS - Q));
  assign hi3     = (step_q >= SW'(STEPS - 3*Q));

  pulse_len_ctr #(
    .LEN_W (LEN_W)
  ) u_len (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger_i (trigger),
    .load_i    (len_load),
    .val_i     (len_val),
    .en_i      (len_en),
    .tick_i    (len_tick),
    .expire_o  (expire)
  );

  always_comb begin
    timer_d  = timer_q;
    step_d   = step_q;
    active_d = active_q;
    if (trigger) begin
      active_d = 1'b1;
      step_d   = '0;
      timer_d  = reload;
    end else if (active_q) begin
      if (timer_q == (FREQ_W+1)'(1)) begin
        timer_d = reload;
        step_d  = step_q + SW'(1);
      end else begin
        timer_d = timer_q - (FREQ_W+1)'(1);
      end
    end
    if (expire) active_d = 1'b0;
  end

  assign out_d = active_q &
    duty_pattern(duty_e'(duty), lo_band, hi1, hi3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q  <= PERIOD_MAX;
      step_q   <= '0;
      active_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      step_q   <= step_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign out    = out_q;
  assign active = active_q;

endmodule

// File: tb/tb_pulse_channel.sv
// Directed bench for pulse_channel at
// FREQ_W=11, STEPS=8, LEN_W=6.
module tb_pulse_channel;

  localparam int FW = 11;
  localparam int ST = 8;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trigger = 1'b0;
  logic [FW-1:0] freq = '0;
  logic [1:0]    duty = '0;
  logic          len_load = 1'b0;
  logic [LW-1:0] len_val = '0;
  logic          len_en = 1'b0;
  logic          len_tick = 1'b0;
  logic          out;
  logic          active;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_channel #(
    .FREQ_W (FW),
    .STEPS  (ST),
    .LEN_W  (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trigger  (trigger),
    .freq     (freq),
    .duty     (duty),
    .len_load (len_load),
    .len_val  (len_val),
    .len_en   (len_en),
    .len_tick (len_tick),
    .out      (out),
    .active   (active)
  );

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trigger = 1'b1;
    len_load = 1'b1; len_val = 6'd5;
    tick_clk(); tick_clk();
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got=%0b exp=0", out);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL reset_active got=%0b exp=0", active);
    end
    checks++;
    if (dut.step_q !== 3'd0) begin
      failures++;
      $display("FAIL reset_step got=%0d exp=0", dut.step_q);
    end
    checks++;
    if (dut.timer_q !== 12'd2048) begin
      failures++;
      $display("FAIL reset_timer got=%0d exp=2048",
               dut.timer_q);
    end
    checks++;
    if (dut.u_len.cnt_q !== 7'd0) begin
      failures++;
      $display("FAIL reset_len got=%0d exp=0",
               dut.u_len.cnt_q);
    end
    trigger = 1'b0; len_load = 1'b0; rst_n = 1'b1;
    tick_clk();
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL idle_active got=%0b exp=0", active);
    end
  endtask

  task automatic test_duty50();
    logic exp;
    freq = 11'd2046; duty = 2'd2; trigger = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick_clk();
      trigger = 1'b0;
      exp = (k >= 2 && k <= 3) || (k >= 12);
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL duty50_T+%0d got=%0b exp=%0b",
                 k, out, exp);
      end
    end
  endtask

  task automatic test_freq_change();
    freq = 11'd2046; duty = 2'd2; trigger = 1'b1;
    tick_clk();
    trigger = 1'b0; freq = 11'd2045;
    tick_clk(); tick_clk();
    checks++;
    if (dut.step_q !== 3'd1 || dut.timer_q !== 12'd3) begin
      failures++;
      $display("FAIL freq_reload got=%0d/%0d exp=1/3",
               dut.step_q, dut.timer_q);
    end
    tick_clk(); tick_clk();
    checks++;
    if (dut.step_q !== 3'd1) begin
      failures++;
      $display("FAIL freq_hold got=%0d exp=1", dut.step_q);
    end
    tick_clk();
    checks++;
    if (dut.step_q !== 3'd2) begin
      failures++;
      $display("FAIL freq_new got=%0d exp=2", dut.step_q);
    end
  endtask

  task automatic test_duty_switch();
    freq = 11'd0; duty = 2'd2; trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    tick_clk();
    checks++;
    if (out !== 1'b1 || dut.timer_q !== 12'd2047) begin
      failures++;
      $display("FAIL sw_pre got=%0b/%0d exp=1/2047",
               out, dut.timer_q);
    end
    duty = 2'd3;
    tick_clk();
    checks++;
    if (out !== 1'b0 || dut.step_q !== 3'd0 ||
        dut.timer_q !== 12'd2046) begin
      failures++;
      $display("FAIL sw_75 got=%0b/%0d/%0d exp=0/0/2046",
               out, dut.step_q, dut.timer_q);
    end
    duty = 2'd1;
    tick_clk();
    checks++;
    if (out !== 1'b1 || dut.timer_q !== 12'd2045) begin
      failures++;
      $display("FAIL sw_25 got=%0b/%0d exp=1/2045",
               out, dut.timer_q);
    end
  endtask

  task automatic test_slow();
    int highs = 0;
    freq = 11'd0; duty = 2'd0; trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    for (int e = 2; e <= 16385; e++) begin
      tick_clk();
      highs += int'(out);
      if (e == 2048) begin
        checks++;
        if (dut.step_q !== 3'd0) begin
          failures++;
          $display("FAIL slow_step0 got=%0d exp=0",
                   dut.step_q);
        end
      end
      if (e == 2049) begin
        checks++;
        if (dut.step_q !== 3'd1) begin
          failures++;
          $display("FAIL slow_step1 got=%0d exp=1",
                   dut.step_q);
        end
      end
    end
    checks++;
    if (highs != 2048) begin
      failures++;
      $display("FAIL slow_high got=%0d exp=2048", highs);
    end
  endtask

  task automatic test_length();
    freq = 11'd0; duty = 2'd2;
    len_val = 6'd62; len_load = 1'b1;
    len_en = 1'b1; trigger = 1'b1;
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd2 || active !== 1'b1) begin
      failures++;
      $display("FAIL len_load got=%0d/%0b exp=2/1",
               dut.u_len.cnt_q, active);
    end
    len_load = 1'b0; trigger = 1'b0;
    len_en = 1'b0; len_tick = 1'b1;
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd2 || out !== 1'b1) begin
      failures++;
      $display("FAIL len_frozen got=%0d/%0b exp=2/1",
               dut.u_len.cnt_q, out);
    end
    len_en = 1'b1;
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd1 || active !== 1'b1) begin
      failures++;
      $display("FAIL len_tick1 got=%0d/%0b exp=1/1",
               dut.u_len.cnt_q, active);
    end
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd0 || active !== 1'b0 ||
        out !== 1'b1) begin
      failures++;
      $display("FAIL len_tick2 got=%0d/%0b/%0b exp=0/0/1",
               dut.u_len.cnt_q, active, out);
    end
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd0 || out !== 1'b0) begin
      failures++;
      $display("FAIL len_after got=%0d/%0b exp=0/0",
               dut.u_len.cnt_q, out);
    end
    len_tick = 1'b0;
  endtask

  task automatic test_trigger_tick();
    trigger = 1'b1;
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd64 || active !== 1'b1) begin
      failures++;
      $display("FAIL trig_max got=%0d/%0b exp=64/1",
               dut.u_len.cnt_q, active);
    end
    len_tick = 1'b1;
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd64) begin
      failures++;
      $display("FAIL trig_tick got=%0d exp=64",
               dut.u_len.cnt_q);
    end
    trigger = 1'b0;
    tick_clk();
    checks++;
    if (dut.u_len.cnt_q !== 7'd63) begin
      failures++;
      $display("FAIL tick_only got=%0d exp=63",
               dut.u_len.cnt_q);
    end
    len_tick = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    tick_clk();
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%0b exp=1", out);
    end
    rst_n = 1'b0;
    tick_clk();
    checks++;
    if (out !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%0b/%0b exp=0/0",
               out, active);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      stray += int'(out | active);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL mid_idle got=%0d exp=0", stray);
    end
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    tick_clk();
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL mid_retrig got=%0b exp=1", out);
    end
  endtask

  initial begin
    test_reset();
    test_duty50();
    test_freq_change();
    test_duty_switch();
    test_slow();
    test_length();
    test_trigger_tick();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
